// File: rtl/bigmem_c_row_streamer.sv
// Row streamer for the 8-fragment C-memory array.
// It fetches one row of 16 words, which is 8 fragments with an A/B pair each.
// It then replays the row as 8 {A,B} beats under a valid/ready handshake.
// This repeats for NumRows rows, each Stride bytes apart, starting at BaseAddr.
module bigmem_c_row_streamer #(
  parameter int ROWS_W = 10
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [31:0]       BaseAddr,
  input  logic [31:0]       Stride,
  input  logic [ROWS_W-1:0] NumRows,
  output logic              Busy,
  output logic              Done,
  output logic [31:0]       Address,
  output logic              cMemRead,
  input  logic [31:0]       i0A,
  input  logic [31:0]       i0B,
  input  logic [31:0]       i1A,
  input  logic [31:0]       i1B,
  input  logic [31:0]       i2A,
  input  logic [31:0]       i2B,
  input  logic [31:0]       i3A,
  input  logic [31:0]       i3B,
  input  logic [31:0]       i4A,
  input  logic [31:0]       i4B,
  input  logic [31:0]       i5A,
  input  logic [31:0]       i5B,
  input  logic [31:0]       i6A,
  input  logic [31:0]       i6B,
  input  logic [31:0]       i7A,
  input  logic [31:0]       i7B,
  output logic [31:0]       OutA,
  output logic [31:0]       OutB,
  output logic [2:0]        OutFrag,
  output logic [ROWS_W-1:0] OutRow,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              OutLast
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM,
    S_DONE
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [31:0]       row_addr;
  logic [31:0]       stride_q;
  logic [ROWS_W-1:0] num_rows_q;
  logic [ROWS_W-1:0] row;
  logic [2:0]        beat;
  logic [31:0]       buf_a [8];
  logic [31:0]       buf_b [8];
  logic [31:0]       frag_a [8];
  logic [31:0]       frag_b [8];

  logic              accept;
  logic              beat_xfer;
  logic              last_row;
  logic              last_beat;

  assign accept    = (state == S_IDLE) && Start && (NumRows != '0);
  assign beat_xfer = (state == S_STREAM) && OutReady;
  assign last_row  = (row == (num_rows_q - ROWS_W'(1)));
  assign last_beat = (beat == 3'd7);

  // Gather the fragment read ports into arrays so the capture can be a loop
  always_comb begin
    frag_a[0] = i0A;  frag_b[0] = i0B;
    frag_a[1] = i1A;  frag_b[1] = i1B;
    frag_a[2] = i2A;  frag_b[2] = i2B;
    frag_a[3] = i3A;  frag_b[3] = i3B;
    frag_a[4] = i4A;  frag_b[4] = i4B;
    frag_a[5] = i5A;  frag_b[5] = i5B;
    frag_a[6] = i6A;  frag_b[6] = i6B;
    frag_a[7] = i7A;  frag_b[7] = i7B;
  end

  // State register; an asynchronous reset aborts any scan in progress without raising Done
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Next-state logic; a start with a zero row count goes straight to DONE
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (Start) next_state = (NumRows != '0) ? S_FETCH : S_DONE;
      S_FETCH:  next_state = S_STREAM;
      S_STREAM: if (beat_xfer && last_beat) next_state = last_row ? S_DONE : S_FETCH;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Scan parameters and row/beat counters; the row address wraps modulo 2^32
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      row_addr   <= '0;
      stride_q   <= '0;
      num_rows_q <= '0;
      row        <= '0;
      beat       <= '0;
    end else begin
      if (accept) begin
        row_addr   <= BaseAddr;
        stride_q   <= Stride;
        num_rows_q <= NumRows;
        row        <= '0;
      end
      if (state == S_FETCH) beat <= '0;
      if (beat_xfer) begin
        beat <= beat + 3'd1;
        if (last_beat && !last_row) begin
          row      <= row + ROWS_W'(1);
          row_addr <= row_addr + stride_q;
        end
      end
    end
  end

  // Capture all 16 fragment words at the end of the single FETCH cycle
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 8; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
    end else if (state == S_FETCH) begin
      for (int i = 0; i < 8; i++) begin
        buf_a[i] <= frag_a[i];
        buf_b[i] <= frag_b[i];
      end
    end
  end

  // Outputs are decoded from state; the beat outputs read as zero outside STREAM
  always_comb begin
    Busy     = (state == S_FETCH) || (state == S_STREAM);
    Done     = (state == S_DONE);
    cMemRead = (state == S_FETCH);
    Address  = row_addr;
    OutValid = 1'b0;
    OutA     = '0;
    OutB     = '0;
    OutFrag  = '0;
    OutRow   = '0;
    OutLast  = 1'b0;
    if (state == S_STREAM) begin
      OutValid = 1'b1;
      OutA     = buf_a[beat];
      OutB     = buf_b[beat];
      OutFrag  = beat;
      OutRow   = row;
      OutLast  = last_beat && last_row;
    end
  end

endmodule

// File: tb/tb_bigmem_c_row_streamer.sv
// Directed bench for bigmem_c_row_streamer.
// The fragment memory is a combinational function of Address.
// Each beat is compared against that function evaluated at the address the bench expects.
module tb_bigmem_c_row_streamer;

  localparam int ROWS_W = 10;

  logic              Clk;
  logic              Rst;
  logic              Start;
  logic [31:0]       BaseAddr;
  logic [31:0]       Stride;
  logic [ROWS_W-1:0] NumRows;
  logic              Busy;
  logic              Done;
  logic [31:0]       Address;
  logic              cMemRead;
  logic [31:0]       i0A, i0B, i1A, i1B, i2A, i2B, i3A, i3B;
  logic [31:0]       i4A, i4B, i5A, i5B, i6A, i6B, i7A, i7B;
  logic [31:0]       OutA;
  logic [31:0]       OutB;
  logic [2:0]        OutFrag;
  logic [ROWS_W-1:0] OutRow;
  logic              OutValid;
  logic              OutReady;
  logic              OutLast;

  int checkCount = 0;
  int errorCount = 0;
  int cycle = 0;
  int startCycle = 0;
  int readCount = 0;
  int readBase = 0;

  // Fragment word model: unique per address, fragment and A/B half
  function automatic logic [31:0] memWord(input logic [31:0] addr, input int frag, input bit isB);
    logic [3:0] half;
    logic [2:0] fragBits;
    half = isB ? 4'hB : 4'hA;
    fragBits = frag[2:0];
    return addr ^ {half, 1'b0, fragBits, 24'hC3C3C3};
  endfunction

  assign i0A = memWord(Address, 0, 1'b0);  assign i0B = memWord(Address, 0, 1'b1);
  assign i1A = memWord(Address, 1, 1'b0);  assign i1B = memWord(Address, 1, 1'b1);
  assign i2A = memWord(Address, 2, 1'b0);  assign i2B = memWord(Address, 2, 1'b1);
  assign i3A = memWord(Address, 3, 1'b0);  assign i3B = memWord(Address, 3, 1'b1);
  assign i4A = memWord(Address, 4, 1'b0);  assign i4B = memWord(Address, 4, 1'b1);
  assign i5A = memWord(Address, 5, 1'b0);  assign i5B = memWord(Address, 5, 1'b1);
  assign i6A = memWord(Address, 6, 1'b0);  assign i6B = memWord(Address, 6, 1'b1);
  assign i7A = memWord(Address, 7, 1'b0);  assign i7B = memWord(Address, 7, 1'b1);

  bigmem_c_row_streamer #(.ROWS_W(ROWS_W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .BaseAddr(BaseAddr), .Stride(Stride),
    .NumRows(NumRows), .Busy(Busy), .Done(Done), .Address(Address), .cMemRead(cMemRead),
    .i0A(i0A), .i0B(i0B), .i1A(i1A), .i1B(i1B), .i2A(i2A), .i2B(i2B), .i3A(i3A), .i3B(i3B),
    .i4A(i4A), .i4B(i4B), .i5A(i5A), .i5B(i5B), .i6A(i6A), .i6B(i6B), .i7A(i7A), .i7B(i7B),
    .OutA(OutA), .OutB(OutB), .OutFrag(OutFrag), .OutRow(OutRow), .OutValid(OutValid),
    .OutReady(OutReady), .OutLast(OutLast)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Count read cycles, sampled midway between rising edges
  always @(negedge Clk) if (cMemRead) readCount++;

  task automatic tick();
    @(posedge Clk);
    #2;
    cycle++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 32'(Busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(Done), 32'd0);
    checkOutput({tag, "_read"}, 32'(cMemRead), 32'd0);
    checkOutput({tag, "_addr"}, Address, 32'd0);
    checkOutput({tag, "_valid"}, 32'(OutValid), 32'd0);
    checkOutput({tag, "_last"}, 32'(OutLast), 32'd0);
    checkOutput({tag, "_outa"}, OutA, 32'd0);
    checkOutput({tag, "_outb"}, OutB, 32'd0);
    checkOutput({tag, "_frag"}, 32'(OutFrag), 32'd0);
    checkOutput({tag, "_row"}, 32'(OutRow), 32'd0);
  endtask

  // Pulse Start for one cycle, then scramble the inputs to prove they were latched
  task automatic applyStimulus(input logic [31:0] base, input logic [31:0] stride, input int rows);
    Start = 1'b1;
    BaseAddr = base;
    Stride = stride;
    NumRows = ROWS_W'(rows);
    readBase = readCount;
    startCycle = cycle;
    tick();
    Start = 1'b0;
    BaseAddr = 32'hBAD0_0000;
    Stride = 32'h0000_0007;
    NumRows = ROWS_W'(9);
  endtask

  task automatic checkFetch(input logic [31:0] addr);
    checkOutput("fetch_read", 32'(cMemRead), 32'd1);
    checkOutput("fetch_addr", Address, addr);
    checkOutput("fetch_busy", 32'(Busy), 32'd1);
    checkOutput("fetch_valid", 32'(OutValid), 32'd0);
    tick();
  endtask

  // Walk one row of beats; with backpressure OutReady follows 1,0,0,1 and every
  // stalled cycle must still present the same beat
  task automatic streamRow(input logic [31:0] addr, input int rowIdx, input bit isLast,
                           input bit backpressure, input int stopAt);
    int k = 0;
    int phase = 0;
    while (k < stopAt) begin
      if (phase >= 64) begin
        checkCount++;
        errorCount++;
        $error("[TB] FAIL beat_timeout: observed beat %0d expected %0d beats", k, stopAt);
        return;
      end
      OutReady = backpressure ? ((phase % 4 == 0) || (phase % 4 == 3)) : 1'b1;
      checkOutput("beat_valid", 32'(OutValid), 32'd1);
      checkOutput("beat_busy", 32'(Busy), 32'd1);
      checkOutput("beat_read", 32'(cMemRead), 32'd0);
      checkOutput("beat_addr", Address, addr);
      checkOutput("beat_frag", 32'(OutFrag), 32'(k));
      checkOutput("beat_row", 32'(OutRow), 32'(rowIdx));
      checkOutput("beat_outa", OutA, memWord(addr, k, 1'b0));
      checkOutput("beat_outb", OutB, memWord(addr, k, 1'b1));
      checkOutput("beat_last", 32'(OutLast), 32'(isLast && (k == 7)));
      if (OutReady) k++;
      phase++;
      tick();
    end
    OutReady = 1'b1;
  endtask

  task automatic checkDone(input int expElapsed, input int expReads);
    checkOutput("done_pulse", 32'(Done), 32'd1);
    checkOutput("done_busy", 32'(Busy), 32'd0);
    checkOutput("done_valid", 32'(OutValid), 32'd0);
    checkOutput("done_read", 32'(cMemRead), 32'd0);
    checkOutput("done_reads", 32'(readCount - readBase), 32'(expReads));
    if (expElapsed >= 0) checkOutput("done_cycles", 32'(cycle - startCycle), 32'(expElapsed));
  endtask

  task automatic runScan(input logic [31:0] base, input logic [31:0] stride, input int rows,
                         input bit backpressure, input int expElapsed);
    logic [31:0] addr;
    applyStimulus(base, stride, rows);
    addr = base;
    for (int r = 0; r < rows; r++) begin
      checkFetch(addr);
      streamRow(addr, r, r == rows - 1, backpressure, 8);
      addr = addr + stride;
    end
    checkDone(expElapsed, rows);
    tick();
    checkOutput("after_done", 32'(Done), 32'd0);
  endtask

  initial begin
    Rst = 1'b1;
    Start = 1'b0;
    BaseAddr = '0;
    Stride = '0;
    NumRows = '0;
    OutReady = 1'b1;
    #1 Rst = 1'b0;
    #2;
    $display("[TB] reset state");
    checkAllZero("reset");
    tick();
    tick();
    Rst = 1'b1;
    tick();

    $display("[TB] single row");
    runScan(32'h0000_0100, 32'h0000_0040, 1, 1'b0, 10);

    $display("[TB] three rows with a Start ignored mid-scan and in DONE");
    applyStimulus(32'h0000_1000, 32'h0000_0020, 3);
    checkFetch(32'h0000_1000);
    streamRow(32'h0000_1000, 0, 1'b0, 1'b0, 8);
    checkFetch(32'h0000_1020);
    Start = 1'b1;
    BaseAddr = 32'hDEAD_0000;
    Stride = 32'h0000_0004;
    NumRows = ROWS_W'(7);
    streamRow(32'h0000_1020, 1, 1'b0, 1'b0, 8);
    Start = 1'b0;
    checkFetch(32'h0000_1040);
    streamRow(32'h0000_1040, 2, 1'b1, 1'b0, 8);
    checkDone(28, 3);
    Start = 1'b1;
    NumRows = ROWS_W'(5);
    BaseAddr = 32'h0000_7000;
    tick();
    Start = 1'b0;
    checkOutput("done_start_busy", 32'(Busy), 32'd0);
    checkOutput("done_start_pulse", 32'(Done), 32'd0);
    tick();
    checkOutput("done_start_idle", 32'(Busy), 32'd0);
    checkOutput("done_start_addr", Address, 32'h0000_1040);

    $display("[TB] backpressure");
    runScan(32'h0000_2000, 32'h0000_0100, 2, 1'b1, -1);

    $display("[TB] zero rows");
    runScan(32'h0000_3000, 32'h0000_0010, 0, 1'b0, 1);

    $display("[TB] address wrap");
    applyStimulus(32'hFFFF_FFE0, 32'h0000_0040, 2);
    checkFetch(32'hFFFF_FFE0);
    streamRow(32'hFFFF_FFE0, 0, 1'b0, 1'b0, 8);
    checkFetch(32'h0000_0020);
    streamRow(32'h0000_0020, 1, 1'b1, 1'b0, 8);
    checkDone(19, 2);
    tick();

    $display("[TB] reset mid-scan");
    applyStimulus(32'h0000_5000, 32'h0000_0010, 3);
    checkFetch(32'h0000_5000);
    streamRow(32'h0000_5000, 0, 1'b0, 1'b0, 8);
    checkFetch(32'h0000_5010);
    streamRow(32'h0000_5010, 1, 1'b0, 1'b0, 3);
    checkOutput("pre_reset_frag", 32'(OutFrag), 32'd3);
    #1 Rst = 1'b0;
    #1;
    checkAllZero("async_reset");
    tick();
    checkOutput("reset_hold_done", 32'(Done), 32'd0);
    tick();
    checkOutput("reset_hold_done2", 32'(Done), 32'd0);
    Rst = 1'b1;
    tick();
    checkOutput("post_reset_idle", 32'(Done), 32'd0);
    runScan(32'h0000_6000, 32'h0000_0008, 1, 1'b0, 10);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
